// File: rtl/game_session_requester_if.sv
`default_nettype none
// ============================================================================
// Module      : game_session_requester_if
// Description : Request/acknowledge link between the game-side session
//               requester and the difficulty controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_session_requester_if;
  logic hard;
  logic med;
  logic easy;
  logic play_hard;
  logic play_medium;
  logic play_easy;
  logic external_reset;

  modport master (
    output hard, med, easy,
    input  play_hard, play_medium, play_easy, external_reset
  );

  modport slave (
    input  hard, med, easy,
    output play_hard, play_medium, play_easy, external_reset
  );
endinterface
`default_nettype wire

// File: rtl/game_session_requester.sv
`default_nettype none
// ============================================================================
// Module      : game_session_requester
// Description : Holds a difficulty request line until acknowledged, then runs
//               the round countdown and reports win / loss / no-ack.
// Revision    : 1.0 - initial release
// ============================================================================
module game_session_requester #(
  parameter int TW          = 8,
  parameter int TIME_EASY   = 90,
  parameter int TIME_MED    = 60,
  parameter int TIME_HARD   = 30,
  parameter int ACK_TIMEOUT = 15
) (
  input  wire                       clock,
  input  wire                       reset,
  input  wire                       start,
  input  wire [1:0]                 select,
  input  wire                       tick,
  input  wire                       at_exit,
  game_session_requester_if.master  link,
  output logic [TW-1:0]             time_left,
  output logic                      game_won,
  output logic                      game_lost,
  output logic                      ack_error,
  output logic                      busy
);

  localparam int          c_cnt_w     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam [c_cnt_w-1:0] c_ack_last = c_cnt_w'(ACK_TIMEOUT - 1);
  localparam [TW-1:0]     c_time_easy = TW'(TIME_EASY);
  localparam [TW-1:0]     c_time_med  = TW'(TIME_MED);
  localparam [TW-1:0]     c_time_hard = TW'(TIME_HARD);
  localparam [TW-1:0]     c_one       = TW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_PLAY    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  logic [1:0]        r_sel;
  logic [c_cnt_w-1:0] r_ack_cnt;
  logic              r_hard, r_med, r_easy;
  logic [TW-1:0]     r_time;
  logic              r_won, r_lost, r_err, r_busy;

  logic              w_ack;
  logic [TW-1:0]     w_load;

  // Only the acknowledge that matches the latched difficulty counts.
  assign w_ack = ((r_sel == 2'b11) && link.play_hard)   ||
                 ((r_sel == 2'b10) && link.play_medium) ||
                 ((r_sel == 2'b01) && link.play_easy);

  always_comb begin
    w_load = c_time_hard;
    case (select)
      2'b01:   w_load = c_time_easy;
      2'b10:   w_load = c_time_med;
      default: w_load = c_time_hard;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sel     <= 2'b00;
      r_ack_cnt <= '0;
      r_hard    <= 1'b0;
      r_med     <= 1'b0;
      r_easy    <= 1'b0;
      r_time    <= '0;
      r_won     <= 1'b0;
      r_lost    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (select != 2'b00)) begin
            r_sel     <= select;
            r_time    <= w_load;
            r_won     <= 1'b0;
            r_lost    <= 1'b0;
            r_err     <= 1'b0;
            r_ack_cnt <= '0;
            r_hard    <= (select == 2'b11);
            r_med     <= (select == 2'b10);
            r_easy    <= (select == 2'b01);
            r_busy    <= 1'b1;
            r_state   <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          if (link.external_reset) begin
            {r_hard, r_med, r_easy} <= 3'b000;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_ack) begin
            r_state <= S_PLAY;
          end else if (r_ack_cnt == c_ack_last) begin
            r_err   <= 1'b1;
            {r_hard, r_med, r_easy} <= 3'b000;
            r_state <= S_DONE;
          end else begin
            r_ack_cnt <= r_ack_cnt + c_cnt_w'(1);
          end
        end
        S_PLAY: begin
          if (link.external_reset) begin
            {r_hard, r_med, r_easy} <= 3'b000;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!w_ack) begin
            // Controller switched away from us: silent abort.
            {r_hard, r_med, r_easy} <= 3'b000;
            r_state <= S_DONE;
          end else if (at_exit) begin
            r_won   <= 1'b1;
            {r_hard, r_med, r_easy} <= 3'b000;
            r_state <= S_DONE;
          end else if (tick) begin
            if (r_time <= c_one) begin
              r_time  <= '0;
              r_lost  <= 1'b1;
              {r_hard, r_med, r_easy} <= 3'b000;
              r_state <= S_DONE;
            end else begin
              r_time <= r_time - c_one;
            end
          end
        end
        S_DONE: begin
          if (link.external_reset) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          {r_hard, r_med, r_easy} <= 3'b000;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign link.hard = r_hard;
  assign link.med  = r_med;
  assign link.easy = r_easy;
  assign time_left = r_time;
  assign game_won  = r_won;
  assign game_lost = r_lost;
  assign ack_error = r_err;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_game_session_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_session_requester
// Description : Directed scoreboard bench; every output change is matched
//               against the next expected output snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_session_requester;

  typedef struct packed {
    logic       hard;
    logic       med;
    logic       easy;
    logic [7:0] tl;
    logic       won;
    logic       lost;
    logic       err;
    logic       busy;
  } snap_t;

  logic       clock;
  logic       reset;
  logic       start;
  logic [1:0] select;
  logic       tick;
  logic       at_exit;
  logic [7:0] time_left;
  logic       game_won, game_lost, ack_error, busy;

  game_session_requester_if sif ();

  game_session_requester dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .select    (select),
    .tick      (tick),
    .at_exit   (at_exit),
    .link      (sif.master),
    .time_left (time_left),
    .game_won  (game_won),
    .game_lost (game_lost),
    .ack_error (ack_error),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    checks = 0;
  int    errors = 0;
  snap_t q[$];
  snap_t prev = '0;

  function automatic snap_t mk(logic h, logic m, logic e, int tl,
                               logic w, logic l, logic er, logic b);
    snap_t s;
    s.hard = h; s.med = m; s.easy = e; s.tl = tl[7:0];
    s.won = w; s.lost = l; s.err = er; s.busy = b;
    return s;
  endfunction

  function automatic snap_t cur_snap();
    return {sif.hard, sif.med, sif.easy, time_left, game_won, game_lost, ack_error, busy};
  endfunction

  // Monitor: every change of the output vector consumes one expected entry.
  always @(negedge clock) begin
    snap_t c;
    snap_t e;
    c = cur_snap();
    if (c !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change actual=%h required=%h", c, prev);
      end else begin
        e = q.pop_front();
        if (c !== e) begin
          errors++;
          $display("FAIL output_change actual=%h required=%h", c, e);
        end
      end
    end
    prev = c;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d required=0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_now(input snap_t exp, input string name);
    snap_t c;
    c = cur_snap();
    checks++;
    if (c !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, c, exp);
    end
  endtask

  task automatic tick_once();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  task automatic do_start(input logic [1:0] sel);
    select = sel;
    start  = 1'b1;
    cyc();
    start  = 1'b0;
  endtask

  task automatic ext_pulse();
    sif.external_reset = 1'b1;
    cyc();
    sif.external_reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; select = 2'b00; tick = 1'b0; at_exit = 1'b0;
    sif.play_hard = 1'b0; sif.play_medium = 1'b0; sif.play_easy = 1'b0;
    sif.external_reset = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check_now(mk(0,0,0,0,0,0,0,0), "reset_state");

    // Easy session run down to 42, then async reset mid-PLAY.
    q.push_back(mk(0,0,1,90,0,0,0,1));
    do_start(2'b01);
    drain("start_easy_latency");
    sif.play_easy = 1'b1;
    cyc(); cyc();
    for (int i = 1; i <= 48; i++) begin
      q.push_back(mk(0,0,1,90-i,0,0,0,1));
      tick_once();
    end
    drain("easy_count_to_42");
    check_now(mk(0,0,1,42,0,0,0,1), "easy_at_42");
    q.push_back(mk(0,0,0,0,0,0,0,0));
    #2 reset = 1'b1;
    #1 check_now(mk(0,0,0,0,0,0,0,0), "async_reset_same_cycle");
    sif.play_easy = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    drain("after_reset");

    // Medium session, late ack, full countdown to a loss.
    q.push_back(mk(0,1,0,60,0,0,0,1));
    do_start(2'b10);
    drain("start_med_latency");
    cyc(); cyc();
    sif.play_medium = 1'b1;
    cyc(); cyc();
    for (int i = 1; i <= 59; i++) begin
      q.push_back(mk(0,1,0,60-i,0,0,0,1));
      tick_once();
    end
    q.push_back(mk(0,0,0,0,0,1,0,1));
    tick_once();
    drain("med_timeout_loss");
    q.push_back(mk(0,0,0,0,0,1,0,0));
    ext_pulse();
    drain("med_ext_reset");
    sif.play_medium = 1'b0;

    // Hard session won with at_exit coincident with a tick.
    q.push_back(mk(1,0,0,30,0,0,0,1));
    do_start(2'b11);
    drain("start_hard_latency");
    sif.play_hard = 1'b1;
    cyc();
    for (int i = 1; i <= 5; i++) begin
      q.push_back(mk(1,0,0,30-i,0,0,0,1));
      tick_once();
    end
    q.push_back(mk(0,0,0,25,1,0,0,1));
    at_exit = 1'b1; tick = 1'b1;
    cyc();
    at_exit = 1'b0; tick = 1'b0;
    drain("hard_exit_win");
    q.push_back(mk(0,0,0,25,1,0,0,0));
    ext_pulse();
    drain("hard_ext_reset");

    // Easy requested, only play_hard offered: ack timeout after ACK_TIMEOUT cycles.
    q.push_back(mk(0,0,1,90,0,0,0,1));
    do_start(2'b01);
    drain("start_easy_noack");
    tick = 1'b1; at_exit = 1'b1;
    for (int i = 0; i < 14; i++) cyc();
    tick = 1'b0; at_exit = 1'b0;
    q.push_back(mk(0,0,0,90,0,0,1,1));
    cyc();
    drain("ack_timeout");

    // start is ignored in DONE and with select=00 in IDLE.
    do_start(2'b11);
    cyc(); cyc();
    drain("start_in_done_ignored");
    q.push_back(mk(0,0,0,90,0,0,1,0));
    ext_pulse();
    drain("noack_ext_reset");
    sif.play_hard = 1'b0;
    do_start(2'b00);
    cyc();
    drain("start_sel00_ignored");
    check_now(mk(0,0,0,90,0,0,1,0), "sel00_flags_kept");

    // Abort from REQUEST, then restart easy.
    q.push_back(mk(0,1,0,60,0,0,0,1));
    do_start(2'b10);
    drain("start_med_again");
    tick_once();
    q.push_back(mk(0,0,0,60,0,0,0,0));
    ext_pulse();
    drain("abort_in_request");
    q.push_back(mk(0,0,1,90,0,0,0,1));
    do_start(2'b01);
    drain("restart_easy");
    q.push_back(mk(0,0,0,90,0,0,0,0));
    ext_pulse();
    drain("final_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/game_session_requester.md
Name: game_session_requester

Overview:
- Game-side peer of the difficulty controller. Turns a player's one-shot difficulty selection into a held hard/med/easy request line.
- Waits for the matching play_* acknowledge, then runs the round countdown.
- Drops the request line on win or timeout, then waits for the controller's external_reset pulse before accepting a new selection.
- Sits between the keypad/switch decoder and the difficulty controller; feeds win/loss status to the display logic.

Parameters:
TW, 8, width of the round countdown (seconds)
TIME_EASY, 90, round budget in ticks for easy
TIME_MED, 60, round budget in ticks for medium
TIME_HARD, 30, round budget in ticks for hard
ACK_TIMEOUT, 15, clock cycles to wait for the play_* acknowledge before aborting

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: latch select and begin a session
select  in  2  difficulty: 01 easy, 10 medium, 11 hard, 00 invalid
tick  in  1  one-cycle 1 Hz enable for the countdown
at_exit  in  1  player has reached the maze exit (level)
play_hard  in  1  controller acknowledge, hard
play_medium  in  1  controller acknowledge, medium
play_easy  in  1  controller acknowledge, easy
external_reset  in  1  controller end-of-game pulse
hard  out  1  request line, hard
med  out  1  request line, medium
easy  out  1  request line, easy
time_left  out  TW  remaining round time
game_won  out  1  sticky: last session won
game_lost  out  1  sticky: last session lost by timeout
ack_error  out  1  sticky: last session aborted, no acknowledge
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE; hard=med=easy=0; time_left=0; game_won=game_lost=ack_error=0; busy=0.
- Request lines are registered and one-hot-or-zero. They are high only in REQUEST and PLAY, and they match the latched select.
- IDLE:
  - start=1 with select!=00: latch select; load time_left with TIME_EASY/MED/HARD; clear all sticky flags; clear the ack counter; next state REQUEST. The request line is high on the following cycle.
  - start with select=00: ignored, no flag change.
- REQUEST:
  - Matching play_* high → PLAY.
  - Non-matching play_* is ignored.
  - Ack counter increments each cycle. When the count reaches ACK_TIMEOUT with no ack → set ack_error, drop the line, go to DONE.
- PLAY:
  - On tick, time_left decrements by 1.
  - tick with time_left=1 → time_left=0, set game_lost, drop the line, go to DONE.
  - at_exit=1 → set game_won, drop the line, go to DONE. This has priority over a same-cycle tick; time_left is then not decremented.
  - Loss of the matching play_* while in PLAY (controller moved away) → treated as abort: drop the line, go to DONE, no flag set.
  - No wrap: time_left never decrements below 0.
- DONE:
  - Lines low; time_left frozen; flags held.
  - Wait for external_reset=1 → IDLE.
  - start is ignored in DONE.
- external_reset in REQUEST or PLAY: immediate abort to IDLE; lines drop next cycle; flags unchanged (all 0).
- external_reset in IDLE: no effect.
- Sticky flags stay set in IDLE until the next valid start; at most one flag is set at a time.
- tick and at_exit are ignored outside PLAY.
- Latency:
  - start → request line: 1 cycle.
  - ack → PLAY: 1 cycle.
  - exit or timeout → line low: 1 cycle.

Test Plan:
- Reset mid-PLAY (easy, time_left=42) → all outputs 0 within the same cycle as reset assertion; state IDLE after release.
- start, select=10; controller acks play_medium after 2 cycles; apply 60 ticks → med high for the whole session, time_left 60→0, game_lost=1, med low; external_reset pulse → busy=0.
- start, select=11; ack; 5 ticks then at_exit coincident with a tick → time_left=25, game_won=1, game_lost=0, hard low next cycle.
- start, select=01; no ack (only play_hard driven) for ACK_TIMEOUT cycles → ack_error=1, easy low, PLAY never entered.
- start with select=00 → no line asserted, busy=0; then a start during DONE → ignored until external_reset.
- external_reset pulsed during REQUEST → lines low next cycle, IDLE, all flags 0; new start with select=01 → easy high, time_left=90.
